// File: rtl/calc_input_sequencer.sv
// Front-end sequencer for the calculator datapath: conditions the buttons and
// rotary encoder, walks operand/opcode entry, then runs the start/done handshake.
module calc_input_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       select,
  input  logic       restart,
  input  logic       rotary_a,
  input  logic       rotary_b,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  input  logic       alu_flag,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  output logic       alu_start,
  output logic [7:0] disp_value,
  output logic [2:0] disp_mode,
  output logic       led_flag,
  output logic       busy
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_ENTER_A  = 3'd0,
    S_ENTER_B  = 3'd1,
    S_ENTER_OP = 3'd2,
    S_START    = 3'd3,
    S_WAIT     = 3'd4,
    S_SHOW     = 3'd5
  } state_t;

  state_t state, state_nx;

  // bit order: 0 select, 1 restart, 2 rotary A, 3 rotary B
  logic [3:0] sync1, sync2;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0] btn_lvl, btn_press;
  logic rot_a_q, step_up, step_dn;
  logic [TO_W-1:0] to_cnt;
  logic [7:0] result;

  logic select_evt, restart_evt, timeout_hit;
  assign select_evt  = btn_press[0];
  assign restart_evt = btn_press[1];
  assign timeout_hit = (to_cnt == TO_LAST);

  // two-flop synchronisers for all raw pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {rotary_b, rotary_a, restart, select};
      sync2 <= sync1;
    end
  end

  // debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
      btn_lvl   <= '0;
      btn_press <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        btn_press[i] <= 1'b0;
        if (sync2[i] == btn_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]    <= '0;
          btn_lvl[i]   <= sync2[i];
          btn_press[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // quadrature decode on synchronised A rising edge, registered step pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_a_q <= 1'b0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else begin
      rot_a_q <= sync2[2];
      step_up <= sync2[2] & ~rot_a_q & ~sync2[3];
      step_dn <= sync2[2] & ~rot_a_q &  sync2[3];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_ENTER_A;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_ENTER_A:  if (select_evt) state_nx = S_ENTER_B;
      S_ENTER_B:  if (select_evt) state_nx = S_ENTER_OP;
      S_ENTER_OP: if (select_evt) state_nx = S_START;
      S_START:    state_nx = S_WAIT;
      S_WAIT:     if (alu_done || timeout_hit) state_nx = S_SHOW;
      S_SHOW:     if (select_evt) state_nx = S_ENTER_A;
      default:    state_nx = S_ENTER_A;
    endcase
    if (restart_evt) state_nx = S_ENTER_A;
  end

  always_comb begin
    alu_start  = 1'b0;
    busy       = 1'b0;
    disp_mode  = state;
    disp_value = 8'h00;
    case (state)
      S_ENTER_A:  disp_value = {4'h0, alu_a};
      S_ENTER_B:  disp_value = {4'h0, alu_b};
      S_ENTER_OP: disp_value = {6'h0, alu_op};
      S_START: begin
        alu_start = 1'b1;
        busy      = 1'b1;
      end
      S_WAIT:     busy = 1'b1;
      S_SHOW:     disp_value = result;
      default:    disp_value = 8'h00;
    endcase
  end

  // operand/opcode entry, result capture and timeout counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      result   <= '0;
      led_flag <= 1'b0;
      to_cnt   <= '0;
    end else if (restart_evt) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      result   <= '0;
      led_flag <= 1'b0;
      to_cnt   <= '0;
    end else begin
      case (state)
        S_ENTER_A: begin
          if (step_up)      alu_a <= alu_a + 4'(1);
          else if (step_dn) alu_a <= alu_a - 4'(1);
        end
        S_ENTER_B: begin
          if (step_up)      alu_b <= alu_b + 4'(1);
          else if (step_dn) alu_b <= alu_b - 4'(1);
        end
        S_ENTER_OP: begin
          if (step_up)      alu_op <= alu_op + 2'(1);
          else if (step_dn) alu_op <= alu_op - 2'(1);
        end
        S_START: to_cnt <= '0;
        S_WAIT: begin
          if (alu_done) begin
            result   <= alu_result;
            led_flag <= alu_flag;
          end else if (timeout_hit) begin
            result   <= 8'hFF;
            led_flag <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_SHOW: if (select_evt) led_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Self-checking bench for calc_input_sequencer: directed scenarios plus
// randomised entry/handshake rounds checked against an arithmetic model.
module tb_calc_input_sequencer;

  localparam int unsigned DB = 4;
  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       select, restart, rotary_a, rotary_b;
  logic       alu_done, alu_flag;
  logic [7:0] alu_result;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic       alu_start, led_flag, busy;
  logic [7:0] disp_value;
  logic [2:0] disp_mode;

  calc_input_sequencer #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .select(select), .restart(restart),
    .rotary_a(rotary_a), .rotary_b(rotary_b), .alu_done(alu_done),
    .alu_result(alu_result), .alu_flag(alu_flag), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .disp_value(disp_value), .disp_mode(disp_mode), .led_flag(led_flag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int starts = 0;

  always @(negedge clk) if (alu_start === 1'b1) starts++;

  // model: 0 A, 1 B, 2 OP, 3 START, 4 WAIT, 5 SHOW
  int m_state, m_a, m_b, m_op, m_res, m_flag;

  function automatic int wrap(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic int exp_disp();
    case (m_state)
      0: return m_a;
      1: return m_b;
      2: return m_op;
      5: return m_res;
      default: return 0;
    endcase
  endfunction

  task automatic model_clear();
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flag = 0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_mode"},  32'(disp_mode),  32'(m_state));
    chk({tag, "_a"},     32'(alu_a),      32'(m_a));
    chk({tag, "_b"},     32'(alu_b),      32'(m_b));
    chk({tag, "_op"},    32'(alu_op),     32'(m_op));
    chk({tag, "_disp"},  32'(disp_value), 32'(exp_disp()));
    chk({tag, "_flag"},  32'(led_flag),   32'(m_flag));
    chk({tag, "_busy"},  32'(busy),       32'(m_state == 3 || m_state == 4));
    chk({tag, "_start"}, 32'(alu_start),  32'(m_state == 3));
  endtask

  // one detent; the model field tracks the current entry state
  task automatic step(input bit ccw);
    rotary_b = ccw;
    tick(3);
    rotary_a = 1'b1;
    tick(4);
    rotary_a = 1'b0;
    tick(3);
    case (m_state)
      0: m_a  = wrap(m_a  + (ccw ? -1 : 1), 16);
      1: m_b  = wrap(m_b  + (ccw ? -1 : 1), 16);
      2: m_op = wrap(m_op + (ccw ? -1 : 1), 4);
      default: ;
    endcase
  endtask

  task automatic press_full();
    select = 1'b1;
    tick(DB + 3);
    select = 1'b0;
    case (m_state)
      0: m_state = 1;
      1: m_state = 2;
      5: begin m_state = 0; m_flag = 0; end
      default: ;
    endcase
    tick(DB + 3);
  endtask

  // press in ENTER_OP; returns in the START cycle with select released
  task automatic go_start();
    select = 1'b1;
    tick(DB + 3);
    select = 1'b0;
    m_state = 3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n, d;
    rst = 1'b0;
    select = 0; restart = 0; rotary_a = 0; rotary_b = 0;
    alu_done = 0; alu_flag = 0; alu_result = 8'h00;
    model_clear();
    tick(2);
    check_all("reset");
    rst = 1'b1;
    tick(2);

    // entry: rotary latency on the first detent, then a=3, b=2 via wrap, op=2
    rotary_b = 1'b0;
    tick(3);
    rotary_a = 1'b1;
    tick(3);
    chk("rot_lat_early", 32'(alu_a), 32'd0);
    tick(1);
    chk("rot_lat", 32'(alu_a), 32'd1);
    rotary_a = 1'b0;
    tick(3);
    m_a = 1;
    repeat (2) step(1'b0);
    press_full();
    repeat (14) step(1'b1);
    press_full();
    repeat (2) step(1'b0);
    check_all("entry_op");
    chk("entry_b_wrap", 32'(alu_b), 32'd2);

    // handshake, with button latency checked on the START press
    s0 = starts;
    select = 1'b1;
    tick(DB + 2);
    chk("press_early", 32'(disp_mode), 32'd2);
    tick(1);
    m_state = 3;
    check_all("start");
    select = 1'b0;
    tick(1);
    m_state = 4;
    check_all("wait");
    tick(3);
    alu_done = 1'b1; alu_result = 8'h06; alu_flag = 1'b0;
    tick(1);
    alu_done = 1'b0; alu_result = 8'hC3;
    m_state = 5; m_res = 8'h06; m_flag = 0;
    check_all("show");
    chk("one_start", 32'(starts - s0), 32'd1);
    step(1'b0);
    check_all("show_step_ignored");
    press_full();
    check_all("back_to_a");

    // timeout, with a stray done during START
    press_full();
    press_full();
    go_start();
    alu_done = 1'b1; alu_result = 8'h11; alu_flag = 1'b0;
    tick(1);
    alu_done = 1'b0;
    m_state = 4;
    tick(TO - 1);
    check_all("wait_before_to");
    tick(1);
    m_state = 5; m_res = 8'hFF; m_flag = 1;
    check_all("timeout");
    tick(DB + 3);
    press_full();
    check_all("to_cleared");

    // debounce: short glitch ignored, clean held press gives one transition
    select = 1'b1;
    tick(DB - 1);
    select = 1'b0;
    tick(DB + 4);
    check_all("glitch");
    select = 1'b1;
    tick(DB + 3);
    m_state = 1;
    check_all("clean_press");
    tick(3 * DB);
    check_all("held");
    select = 1'b0;
    tick(DB + 3);

    // priority: restart beats select in ENTER_OP with a=5, b=7
    restart = 1'b1;
    tick(DB + 3);
    restart = 1'b0;
    tick(DB + 3);
    model_clear();
    check_all("restart");
    repeat (5) step(1'b0);
    press_full();
    repeat (7) step(1'b0);
    press_full();
    step(1'b0);
    check_all("prio_setup");
    select = 1'b1; restart = 1'b1;
    tick(DB + 3);
    select = 1'b0; restart = 1'b0;
    model_clear();
    check_all("priority");
    tick(DB + 3);
    alu_done = 1'b1; alu_result = 8'h5A; alu_flag = 1'b1;
    tick(1);
    alu_done = 1'b0;
    tick(1);
    check_all("stray_done");

    // randomised rounds
    for (int it = 0; it < 4; it++) begin
      for (int f = 0; f < 3; f++) begin
        n = int'($urandom_range(0, 12));
        repeat (n) step(1'($urandom % 2));
        if (f < 2) press_full();
      end
      check_all("rnd_op");
      go_start();
      check_all("rnd_start");
      tick(1);
      m_state = 4;
      if ($urandom % 4 == 0) begin
        tick(TO);
        m_res = 8'hFF; m_flag = 1;
      end else begin
        d = int'($urandom_range(1, TO));
        tick(d - 1);
        alu_result = 8'($urandom);
        alu_flag = 1'($urandom);
        alu_done = 1'b1;
        tick(1);
        alu_done = 1'b0;
        m_res = int'(alu_result); m_flag = int'(alu_flag);
      end
      m_state = 5;
      check_all("rnd_show");
      tick(DB + 3);
      press_full();
      check_all("rnd_back");
    end

    // asynchronous reset in WAIT
    press_full();
    press_full();
    go_start();
    tick(1);
    m_state = 4;
    tick(2);
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check_all("async_rst");
    s0 = starts;
    tick(2);
    rst = 1'b1;
    tick(6);
    check_all("after_rst");
    chk("no_start_after_rst", 32'(starts - s0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
